// File: rtl/button_pkg.sv
// Shared types and constants for the push-button debouncer and its helpers.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

    localparam int                      GLITCH_WIDTH = 8;
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX   = 8'd255;

    // Debug counter that parks at its maximum instead of wrapping.
    function automatic logic [GLITCH_WIDTH-1:0] sat_inc(input logic [GLITCH_WIDTH-1:0] v);
        return (v == GLITCH_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; reusable for any
// slow asynchronous pin (buttons, switches, reset request lines).
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw button pin, producing a clean level, press/
// release pulses and a glitch count. Define AUTO_REPEAT_EN for held-key repeat.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_in,
    output logic                    btn_level,
    output logic                    press_pulse,
    output logic                    release_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    debounce_state_t      state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 s;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] RPT_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic [CNT_WIDTH-1:0] rpt_cnt;
    logic                 rpt_armed;  // first repeat already fired; use the period
`endif

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            glitch_count  <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt       <= '0;
            rpt_armed     <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!s) begin
                        state        <= IDLE;
                        glitch_count <= sat_inc(glitch_count);
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rpt_cnt == (rpt_armed ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                        press_pulse <= 1'b1;
                        rpt_cnt     <= '0;
                        rpt_armed   <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
`endif
                end

                RELEASE_WAIT: begin
                    // The repeat counter is frozen here so a release glitch
                    // does not restart the initial repeat delay.
                    if (s) begin
                        state        <= PRESSED;
                        glitch_count <= sat_inc(glitch_count);
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt_cnt       <= '0;
                        rpt_armed     <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected pulse cycles are queued as
// the button is driven and matched against pulses seen on the outputs.
module tb_button_debouncer;

    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int CW  = 8;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int LAT = SS + 1 + DB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] glitch_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH      (CW),
        .SYNC_STAGES    (SS),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_press;
        int at;
    } pulse_t;

    pulse_t sb[$];
    pulse_t ev;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input bit is_press, input int at);
        pulse_t p;
        p.is_press = is_press;
        p.at       = at;
        sb.push_back(p);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   btn_level,     0);
        check({tag, "_press"},   press_pulse,   0);
        check({tag, "_release"}, release_pulse, 0);
        check({tag, "_glitch"},  glitch_count,  0);
    endtask

    // Clean press held for `hold` cycles, then a clean release.
    task automatic press_release(input int hold);
        int c;
        c      = cyc;
        btn_in = 1'b1;
        expect_pulse(1'b1, c + LAT);
`ifdef AUTO_REPEAT_EN
        begin
            int e;
            e = c + LAT + RD;
            while (e <= c + hold + 2) begin
                expect_pulse(1'b1, e);
                e += RP;
            end
        end
`endif
        tick(hold);
        check("held_level", btn_level, 1);
        btn_in = 1'b0;
        expect_pulse(1'b0, cyc + LAT);
        tick(20);
        check("released_level", btn_level, 0);
    endtask

    // Every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (press_pulse || release_pulse) begin
            check("pulse_exclusive", int'(press_pulse & release_pulse), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                ev = sb.pop_front();
                check(ev.is_press ? "press_at" : "release_at", cyc, ev.at);
                check("pulse_kind", press_pulse, ev.is_press);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b0;
        btn_in = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;
        tick(3);

        // Clean press and release.
        press_release(20);
        check("glitch_after_clean", glitch_count, 0);

        // Short high pulse rejected in PRESS_WAIT.
        btn_in = 1'b1;
        tick(2);
        btn_in = 1'b0;
        tick(10);
        check("glitch_press_count", glitch_count, 1);
        check("glitch_press_level", btn_level, 0);

        // Release bounce rejected in RELEASE_WAIT, then a real release.
        begin
            int c;
            c      = cyc;
            btn_in = 1'b1;
            expect_pulse(1'b1, c + LAT);
            tick(10);
            btn_in = 1'b0;
            tick(2);
            btn_in = 1'b1;
            tick(4);
            check("bounce_level_held", btn_level, 1);
            btn_in = 1'b0;
            expect_pulse(1'b0, cyc + LAT);
            tick(20);
            check("glitch_release_count", glitch_count, 2);
            check("bounce_level_final", btn_level, 0);
        end

        // Reset in the middle of PRESS_WAIT with the button still held.
        btn_in = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(1);
        check_all_zero("midreset");
        tick(2);
        reset = 1'b1;
        expect_pulse(1'b1, cyc + LAT);
        tick(12);
        check("after_reset_level", btn_level, 1);
        btn_in = 1'b0;
        expect_pulse(1'b0, cyc + LAT);
        tick(20);

        // Glitch counter saturation.
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'b1;
            tick(1);
            btn_in = 1'b0;
            tick(5);
            if (i == 199) check("glitch_count_200", glitch_count, 200);
        end
        tick(5);
        check("glitch_saturated", glitch_count, 255);
        check("glitch_sat_level", btn_level, 0);

        // Long hold (repeat pulses expected only with AUTO_REPEAT_EN).
        press_release(40);
        check("glitch_still_saturated", glitch_count, 255);

        tick(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
